logic_op_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's single-bit behavioural gate primitives.
- Applies one of eight bitwise logic operations (including NOR) to two WIDTH-bit operands.
- Optionally OR-reduces the bitwise result to a single bit.
- Results are delivered through a 2-entry output buffer with valid/ready handshakes on both sides; a saturating transaction counter is provided for debug.

---
 rtl/logic_op_pkg.sv | 32 +++
 rtl/logic_op_fifo2.sv | 53 +++++
 rtl/logic_op_pipe.sv | 68 ++++++
 tb/tb_logic_op_pipe.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic_op_pipe block: operation codes and the
// per-bit logic function applied across the operand width.
package logic_op_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_PASS = 3'b110,
    OP_NOTA = 3'b111
  } op_e;

  // Per-bit so it stays width-agnostic; the caller applies it to each bit.
  function automatic logic op_bit(input logic a, input logic b, input op_e op);
    logic r;
    unique case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_PASS: r = a;
      OP_NOTA: r = ~a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_fifo2.sv
// Two-entry result FIFO with valid/ready on both sides. The push side's
// ready is a function of the registered fill count only.
module logic_op_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_pop_valid,
  input  logic             i_pop_ready,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [2];
  logic [1:0]       r_count;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_push_ready = (r_count != 2'd2);
  assign o_pop_valid  = (r_count != 2'd0);
  assign w_push       = i_push_valid && o_push_ready;
  assign w_pop        = o_pop_valid && i_pop_ready;
  assign o_data       = o_pop_valid ? r_mem[r_rd_ptr] : '0;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; entries are only observable
  // through r_count, which is, and o_data is forced to zero when empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Bitwise logic operation unit with optional OR-reduction, a 2-entry
// output buffer and a saturating count of accepted transactions.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_red,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] ops_count
);

  logic [WIDTH-1:0] w_bitwise;
  logic [WIDTH-1:0] w_result;
  logic             w_accept;
  logic [CNT_W-1:0] r_ops_count;

  assign w_accept  = in_valid && in_ready;
  assign ops_count = r_ops_count;

  // NOTE: every always_comb output is given a default before any branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_bitwise = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bitwise[i] = op_bit(in_a[i], in_b[i], op_e'(in_op));
    end
  end

  // Written bit-wise rather than with a replication so WIDTH == 1 is legal.
  always_comb begin
    w_result = '0;
    if (in_red) w_result[0] = |w_bitwise;
    else        w_result    = w_bitwise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ops_count <= '0;
    end else if (w_accept && (r_ops_count != {CNT_W{1'b1}})) begin
      r_ops_count <= r_ops_count + CNT_W'(1);
    end
  end

  logic_op_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push_valid (in_valid),
    .o_push_ready (in_ready),
    .i_data       (w_result),
    .o_pop_valid  (out_valid),
    .i_pop_ready  (out_ready),
    .o_data       (out_data)
  );

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe: the driver queues hand-computed
// results on accept, a monitor pops and compares on each output handshake.
module tb_logic_op_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       in_op = '0;
  logic             in_red = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] ops_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc = 0;
  logic [WIDTH-1:0] exp_q [$];

  logic_op_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_red    (in_red),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ops_count (ops_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] cnt_model(input int n);
    return (n >= CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(n);
  endfunction

  // Monitor: compare each handshaken output against the scoreboard and
  // verify data is held while the consumer stalls.
  logic [WIDTH-1:0] held_data;
  logic             held_v = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) check("hold_stable", 32'(out_data), 32'(held_data));
      if (!out_valid) check("empty_data", 32'(out_data), 32'h0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'(exp_q.size()), 32'd1);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        held_v = 1'b0;
      end else if (out_valid) begin
        held_data = out_data;
        held_v    = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic red, input logic [7:0] exp);
    int cyc = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_red = red; in_valid = 1'b1;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    n_acc++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("ops_count", 32'(ops_count), 32'(cnt_model(n_acc)));
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while held in reset.
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_ops_count", 32'(ops_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // First transaction: NOR of zeros, valid one cycle after accept.
    send(8'h00, 8'h00, 3'b011, 1'b0, 8'hFF);
    check("latency_valid", 32'(out_valid), 32'd1);

    // Sweep all ops back to back; counter saturates at 3 along the way.
    send(8'h0F, 8'h3C, 3'b000, 1'b0, 8'h0C);
    send(8'h0F, 8'h3C, 3'b001, 1'b0, 8'h3F);
    send(8'h0F, 8'h3C, 3'b010, 1'b0, 8'hF3);
    send(8'h0F, 8'h3C, 3'b011, 1'b0, 8'hC0);
    send(8'h0F, 8'h3C, 3'b100, 1'b0, 8'h33);
    send(8'h0F, 8'h3C, 3'b101, 1'b0, 8'hCC);
    send(8'h0F, 8'h3C, 3'b110, 1'b0, 8'h0F);
    send(8'h0F, 8'h3C, 3'b111, 1'b0, 8'hF0);

    // Reduction.
    send(8'h01, 8'h00, 3'b011, 1'b1, 8'h01);
    send(8'hFF, 8'h00, 3'b011, 1'b1, 8'h00);
    send(8'h0F, 8'hF0, 3'b000, 1'b1, 8'h00);
    send(8'h0F, 8'h3C, 3'b100, 1'b1, 8'h01);
    drain();

    // Backpressure: two fill the buffer, third waits until the consumer resumes.
    out_ready = 1'b0;
    send(8'hF0, 8'h3C, 3'b000, 1'b0, 8'h30);
    send(8'h01, 8'h02, 3'b001, 1'b0, 8'h03);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    fork
      send(8'h5A, 8'h00, 3'b111, 1'b0, 8'hA5);
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with a full buffer, checked between clock edges.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'b001, 1'b0, 8'h36);
    send(8'h12, 8'h34, 3'b100, 1'b0, 8'h26);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_ops_count", 32'(ops_count), 32'd0);
    check("arst_out_data",  32'(out_data),  32'h0);
    exp_q.delete();
    n_acc = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'hC3, 8'h00, 3'b110, 1'b0, 8'hC3);
    drain();
    @(negedge clk);
    check("final_idle", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
